// File: rtl/wb_pkg.sv
// Shared types and default widths for the Wishbone N-slave interconnect.
package wb_pkg;

    localparam int unsigned DefaultDataW = 32;
    localparam int unsigned DefaultAddrW = 32;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone
    } wb_state_e;

    // Slave-select field width; a single slave still gets a 1-bit field.
    function automatic int unsigned sel_width(input int unsigned n_slaves);
        return (n_slaves > 1) ? $clog2(n_slaves) : 1;
    endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational slave-select decode: index, one-hot strobe vector and in-range flag.
module wb_addr_decode #(
    parameter int unsigned N_SLAVES = 16,
    parameter int unsigned SEL_W    = 4
) (
    input  logic [SEL_W-1:0]    sel_i,
    output logic [SEL_W-1:0]    idx_o,
    output logic [N_SLAVES-1:0] onehot_o,
    output logic                in_range_o
);

    assign idx_o      = sel_i;
    assign in_range_o = 32'(sel_i) < N_SLAVES;

    always_comb begin
        onehot_o = '0;
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
            onehot_o[i] = (32'(sel_i) == i);
        end
    end

endmodule

// File: rtl/wb_intercon_n.sv
// Single-master Wishbone interconnect to N slaves selected by an address field.
// Defining WB_TIMEOUT_EN adds an ACK timeout that ends a stalled request with an error.
module wb_intercon_n
    import wb_pkg::*;
#(
    parameter int unsigned N_SLAVES = 16,
    parameter int unsigned DATA_W   = DefaultDataW,
    parameter int unsigned ADDR_W   = DefaultAddrW,
    parameter int unsigned SEL_LSB  = 28,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       master_STB,
    input  logic                       master_WE,
    input  logic [ADDR_W-1:0]          master_ADDR,
    input  logic [DATA_W-1:0]          master_DAT_I,
    output logic [DATA_W-1:0]          master_DAT_O,
    output logic                       master_ACK,
    output logic                       master_ERR,
    output logic [N_SLAVES-1:0]        slave_STB,
    output logic [N_SLAVES-1:0]        slave_WE,
    input  logic [N_SLAVES-1:0]        slave_ACK,
    output logic [ADDR_W-1:0]          slave_ADDR,
    output logic [DATA_W-1:0]          slave_DAT_O,
    input  logic [N_SLAVES*DATA_W-1:0] slave_DAT_I
);

    localparam int unsigned SelW = sel_width(N_SLAVES);

    if (N_SLAVES < 1 || N_SLAVES > 32 || TIMEOUT < 1 || TIMEOUT > 65535 ||
        SEL_LSB + SelW > ADDR_W) begin : g_param_check
        $error("wb_intercon_n: parameter out of range");
    end

    wb_state_e         state_q, state_d;
    logic              armed_q, armed_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;
    logic [DATA_W-1:0] rdat_q, rdat_d;

    logic [SelW-1:0]     dec_sel;
    logic [SelW-1:0]     dec_idx;
    logic [N_SLAVES-1:0] dec_onehot;
    logic                dec_in_range;
    logic                ack_sel;

`ifdef WB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
`endif

    // Decode the live address while idle, the latched one for the rest of the transfer.
    assign dec_sel = (state_q == StIdle) ? master_ADDR[SEL_LSB +: SelW]
                                         : addr_q[SEL_LSB +: SelW];

    wb_addr_decode #(
        .N_SLAVES (N_SLAVES),
        .SEL_W    (SelW)
    ) u_decode (
        .sel_i      (dec_sel),
        .idx_o      (dec_idx),
        .onehot_o   (dec_onehot),
        .in_range_o (dec_in_range)
    );

    assign ack_sel = |(slave_ACK & dec_onehot);

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        we_d    = we_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
`ifdef WB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        if (!master_STB) begin
            armed_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (master_STB && armed_q) begin
                    addr_d = master_ADDR;
                    wdat_d = master_DAT_I;
                    we_d   = master_WE;
`ifdef WB_TIMEOUT_EN
                    cnt_d  = '0;
`endif
                    if (dec_in_range) begin
                        state_d = StReq;
                        err_d   = 1'b0;
                    end else begin
                        state_d = StDone;
                        err_d   = 1'b1;
                        rdat_d  = '0;
                    end
                end
            end
            StReq: begin
                if (ack_sel) begin
                    state_d = StDone;
                    err_d   = 1'b0;
                    rdat_d  = we_q ? '0 : slave_DAT_I[32'(dec_idx) * DATA_W +: DATA_W];
                end
`ifdef WB_TIMEOUT_EN
                else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                    rdat_d  = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            StDone: begin
                // Disarm so a still-held STB cannot launch a second transfer.
                state_d = StIdle;
                armed_d = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            armed_q <= 1'b1;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
        end
    end

`ifdef WB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign master_DAT_O = rdat_q;
    assign master_ACK   = (state_q == StDone);
    assign master_ERR   = master_ACK & err_q;
    assign slave_STB    = (state_q == StReq) ? dec_onehot : '0;
    assign slave_WE     = slave_STB & {N_SLAVES{we_q}};
    assign slave_ADDR   = addr_q;
    assign slave_DAT_O  = wdat_q;

endmodule

// File: tb/tb_wb_intercon_n.sv
// Self-checking bench for wb_intercon_n: directed and random transfers against a transfer-level model.
module tb_wb_intercon_n;

    localparam int unsigned NS     = 5;
    localparam int unsigned DW     = 32;
    localparam int unsigned AW     = 32;
    localparam int unsigned SelLsb = 28;
    localparam int unsigned Tmo    = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             master_STB;
    logic             master_WE;
    logic [AW-1:0]    master_ADDR;
    logic [DW-1:0]    master_DAT_I;
    logic [DW-1:0]    master_DAT_O;
    logic             master_ACK;
    logic             master_ERR;
    logic [NS-1:0]    slave_STB;
    logic [NS-1:0]    slave_WE;
    logic [NS-1:0]    slave_ACK;
    logic [AW-1:0]    slave_ADDR;
    logic [DW-1:0]    slave_DAT_O;
    logic [NS*DW-1:0] slave_DAT_I;

    int tests = 0;
    int fails = 0;

    // Slave model: wait_cfg = wait states before ACK, -1 = never answers.
    int            wait_cfg [NS] = '{default: 0};
    logic [DW-1:0] sdat     [NS] = '{default: '0};
    int            scnt     [NS] = '{default: 0};
    logic [NS-1:0] noise = '0;

    always #5 clk = ~clk;

    wb_intercon_n #(
        .N_SLAVES (NS),
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .SEL_LSB  (SelLsb),
        .TIMEOUT  (Tmo)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .master_STB   (master_STB),
        .master_WE    (master_WE),
        .master_ADDR  (master_ADDR),
        .master_DAT_I (master_DAT_I),
        .master_DAT_O (master_DAT_O),
        .master_ACK   (master_ACK),
        .master_ERR   (master_ERR),
        .slave_STB    (slave_STB),
        .slave_WE     (slave_WE),
        .slave_ACK    (slave_ACK),
        .slave_ADDR   (slave_ADDR),
        .slave_DAT_O  (slave_DAT_O),
        .slave_DAT_I  (slave_DAT_I)
    );

    always_comb begin
        for (int i = 0; i < NS; i++) begin
            slave_ACK[i] = (slave_STB[i] && wait_cfg[i] >= 0 && scnt[i] == wait_cfg[i]) ||
                           (noise[i] && !slave_STB[i]);
            slave_DAT_I[i*DW +: DW] = sdat[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            scnt[i] <= slave_STB[i] ? scnt[i] + 1 : 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_txn(input logic [AW-1:0] addr, input bit we, input logic [DW-1:0] wdat,
                           input int hold);
        int            idx;
        int            lat;
        int            exp_str;
        bit            exp_err;
        logic [DW-1:0] exp_dat;
        logic [NS-1:0] exp_oh;
        int            budget;
        int            str_cycles;
        int            ack_cyc;
        logic          err_at_ack;
        logic [DW-1:0] dat_at_ack;
        int            extra;

        idx    = int'((addr >> SelLsb) & 32'h7);
        exp_oh = NS'(1) << idx;
        if (idx >= int'(NS)) begin
            lat = 1; exp_err = 1'b1; exp_dat = '0; exp_str = 0;
        end else if (wait_cfg[idx] < 0) begin
`ifdef WB_TIMEOUT_EN
            lat = Tmo + 1; exp_err = 1'b1; exp_dat = '0; exp_str = Tmo;
`else
            lat = -1; exp_err = 1'b0; exp_dat = '0; exp_str = 0;
`endif
        end else begin
            lat     = wait_cfg[idx] + 2;
            exp_err = 1'b0;
            exp_dat = we ? '0 : sdat[idx];
            exp_str = wait_cfg[idx] + 1;
        end
        budget = (lat < 0) ? 1000 : lat + 20;

        @(negedge clk);
        master_STB   = 1'b1;
        master_WE    = we;
        master_ADDR  = addr;
        master_DAT_I = wdat;
        str_cycles = 0;
        ack_cyc    = 0;
        err_at_ack = 1'b0;
        dat_at_ack = '0;
        for (int c = 1; c <= budget && ack_cyc == 0; c++) begin
            @(negedge clk);
            if (slave_STB != '0) begin
                str_cycles++;
                chk("slave_stb", slave_STB, exp_oh);
                chk("slave_we", slave_WE, we ? exp_oh : '0);
                chk("slave_addr", slave_ADDR, addr);
                chk("slave_dat_o", slave_DAT_O, wdat);
            end
            if (master_ACK) begin
                ack_cyc    = c;
                err_at_ack = master_ERR;
                dat_at_ack = master_DAT_O;
                chk("stb_at_ack", slave_STB, 0);
            end
            noise = NS'($urandom);
        end

        if (lat < 0) begin
            chk("no_ack", ack_cyc, 0);
        end else begin
            chk("ack_latency", ack_cyc, lat);
            chk("err", err_at_ack, exp_err);
            chk("dat", dat_at_ack, exp_dat);
            chk("stb_cycles", str_cycles, exp_str);
        end

        extra = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (slave_STB != '0 || master_ACK) extra++;
        end
        if (hold > 0) chk("held_stb_extra", extra, 0);
        master_STB = 1'b0;
        @(negedge clk);
        chk("ack_one_cycle", master_ACK, 0);
        if (lat >= 0) chk("dat_hold", master_DAT_O, exp_dat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        master_STB   = 1'b0;
        master_WE    = 1'b0;
        master_ADDR  = '0;
        master_DAT_I = '0;
        repeat (3) @(negedge clk);
        chk("rst_dat_o", master_DAT_O, 0);
        chk("rst_ack", master_ACK, 0);
        chk("rst_err", master_ERR, 0);
        chk("rst_stb", slave_STB, 0);
        chk("rst_we", slave_WE, 0);
        chk("rst_saddr", slave_ADDR, 0);
        chk("rst_sdat", slave_DAT_O, 0);
        reset = 1'b0;
        @(negedge clk);

        // Zero-wait read from slave 1.
        wait_cfg[1] = 0;
        sdat[1]     = 32'hDEAD_BEEF;
        run_txn(32'h1000_0004, 1'b0, $urandom, 0);

        // Write to slave 0 with three wait states.
        wait_cfg[0] = 3;
        run_txn(32'h0000_0010, 1'b1, 32'h1234_5678, 0);

        // Decode error: index 7 with five slaves.
        run_txn(32'h7000_0000, 1'b0, $urandom, 0);

        // STB held after ACK must not start another transfer; then a fresh one works.
        wait_cfg[3] = 1;
        sdat[3]     = $urandom | 32'h1;
        run_txn(32'h3000_0100, 1'b0, $urandom, 5);
        run_txn(32'h3000_0200, 1'b0, $urandom, 0);

        // Reset in the second REQ cycle.
        wait_cfg[2] = 3;
        sdat[2]     = $urandom | 32'h1;
        @(negedge clk);
        master_STB   = 1'b1;
        master_WE    = 1'b0;
        master_ADDR  = 32'h2000_0040;
        master_DAT_I = 32'hCAFE_0001;
        @(negedge clk);
        chk("rq1_stb", slave_STB, 5'b00100);
        @(negedge clk);
        reset      = 1'b1;
        master_STB = 1'b0;
        @(negedge clk);
        chk("rreq_stb", slave_STB, 0);
        chk("rreq_we", slave_WE, 0);
        chk("rreq_ack", master_ACK, 0);
        chk("rreq_err", master_ERR, 0);
        chk("rreq_dat", master_DAT_O, 0);
        chk("rreq_saddr", slave_ADDR, 0);
        chk("rreq_sdat", slave_DAT_O, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ack", master_ACK, 0);
        run_txn(32'h2000_0040, 1'b0, $urandom, 0);

        // Silent slave 2: timeout error, or indefinite wait without the timeout.
        wait_cfg[2] = -1;
        run_txn(32'h2000_0000, 1'b0, $urandom, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NS; i++) begin
                wait_cfg[i] = int'($urandom_range(0, 4));
                sdat[i]     = $urandom;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_txn($urandom, 1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
